// File: rtl/calc_pkg.sv
// Shared definitions for the tiny calculator: display serializer state
// encoding and the default display-chain geometry.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOW   = 2'd1,
        HIGH  = 2'd2,
        LATCH = 2'd3
    } sr_state_t;

    localparam int DISP_WIDTH = 16;
    localparam int SR_DIV     = 2;

endpackage

// File: rtl/shift_out_driver.sv
// Display serializer: accepts one frame per valid/ready handshake, shifts it
// MSB-first into a 74HC595-style chain, then pulses the storage latch.
module shift_out_driver
    import calc_pkg::*;
#(
    parameter int WIDTH = DISP_WIDTH,
    parameter int DIV   = SR_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_sr_data,
    output logic             o_sr_clk,
    output logic             o_sr_latch
);

    localparam int DCW = $clog2(DIV + 1);
    localparam int BCW = $clog2(WIDTH + 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    sr_state_t        state_reg, state_next;
    logic [DCW-1:0]   div_cnt_reg, div_cnt_next;
    logic [BCW-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic             sr_data_reg, sr_data_next;
    logic             sr_clk_reg, sr_clk_next;
    logic             sr_latch_reg, sr_latch_next;

    logic             div_done;
    logic [WIDTH-1:0] shift_left;

    assign div_done   = (div_cnt_reg == DIV_LAST);
    assign shift_left = shift_reg << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            sr_data_reg  <= 1'b0;
            sr_clk_reg   <= 1'b0;
            sr_latch_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_cnt_reg  <= div_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            sr_data_reg  <= sr_data_next;
            sr_clk_reg   <= sr_clk_next;
            sr_latch_reg <= sr_latch_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        sr_data_next  = sr_data_reg;
        sr_clk_next   = sr_clk_reg;
        sr_latch_next = sr_latch_reg;

        case (state_reg)
            IDLE: begin
                // o_ready is high throughout IDLE, so valid alone completes the handshake
                if (i_valid) begin
                    state_next    = LOW;
                    shift_next    = i_data;
                    bit_cnt_next  = BIT_LAST;
                    div_cnt_next  = '0;
                    sr_data_next  = i_data[WIDTH-1];
                    sr_clk_next   = 1'b0;
                    sr_latch_next = 1'b0;
                end
            end
            LOW: begin
                if (div_done) begin
                    state_next   = HIGH;
                    div_cnt_next = '0;
                    sr_clk_next  = 1'b1;
                end else begin
                    div_cnt_next = div_cnt_reg + DCW'(1);
                end
            end
            HIGH: begin
                if (div_done) begin
                    div_cnt_next = '0;
                    sr_clk_next  = 1'b0;
                    if (bit_cnt_reg == '0) begin
                        state_next    = LATCH;
                        sr_data_next  = 1'b0;
                        sr_latch_next = 1'b1;
                    end else begin
                        // data only moves when entering LOW, keeping it stable across HIGH
                        state_next   = LOW;
                        shift_next   = shift_left;
                        sr_data_next = shift_left[WIDTH-1];
                        bit_cnt_next = bit_cnt_reg - BCW'(1);
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + DCW'(1);
                end
            end
            LATCH: begin
                if (div_done) begin
                    state_next    = IDLE;
                    div_cnt_next  = '0;
                    sr_latch_next = 1'b0;
                end else begin
                    div_cnt_next = div_cnt_reg + DCW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_ready    = (state_reg == IDLE) && !rst;
    assign o_sr_data  = sr_data_reg;
    assign o_sr_clk   = sr_clk_reg;
    assign o_sr_latch = sr_latch_reg;

endmodule

// File: tb/tb_shift_out_driver.sv
// Bench for shift_out_driver: a behavioural 595 chain model captures what the
// serial pins deliver, checked against the frames handed over by the bench.
module tb_shift_out_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // default geometry instance (16 bits, DIV=2)
    logic [15:0] data0  = '0;
    logic        valid0 = 1'b0;
    logic        ready0, sd0, sc0, sl0;

    // edge geometry instance (1 bit, DIV=1)
    logic [0:0]  data1  = '0;
    logic        valid1 = 1'b0;
    logic        ready1, sd1, sc1, sl1;

    shift_out_driver #(.WIDTH(16), .DIV(2)) u_dut0 (
        .clk(clk), .rst(rst), .i_data(data0), .i_valid(valid0),
        .o_ready(ready0), .o_sr_data(sd0), .o_sr_clk(sc0), .o_sr_latch(sl0)
    );

    shift_out_driver #(.WIDTH(1), .DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_data(data1), .i_valid(valid1),
        .o_ready(ready1), .o_sr_data(sd1), .o_sr_clk(sc1), .o_sr_latch(sl1)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- 595 chain models (sampled on the falling edge) ----------
    logic        pc0 = 0, pd0 = 0, pl0 = 0, pr0 = 0;
    logic [15:0] chain0 = '0;
    int          rise0 = 0, stab0 = 0, hp0_len = 0, hp0_err = 0;
    int          lat0_len = 0, lat0_last = 0;
    int          acc0_q[$];
    int          rdy0_q[$];
    logic [15:0] latq0[$];

    always @(negedge clk) begin
        if (valid0 && ready0) acc0_q.push_back(cyc + 1);
        if (ready0 && !pr0)   rdy0_q.push_back(cyc + 1);
        if (sc0 && !pc0) begin
            chain0  = {chain0[14:0], sd0};
            rise0   = rise0 + 1;
            hp0_len = 1;
        end else if (sc0) begin
            hp0_len = hp0_len + 1;
            if (sd0 !== pd0) stab0 = stab0 + 1;
        end else if (pc0 && hp0_len != 2) begin
            hp0_err = hp0_err + 1;
        end
        if (sl0 && !pl0) begin
            latq0.push_back(chain0);
            lat0_len = 1;
        end else if (sl0) begin
            lat0_len = lat0_len + 1;
        end else if (pl0) begin
            lat0_last = lat0_len;
        end
        pc0 = sc0; pd0 = sd0; pl0 = sl0; pr0 = ready0;
    end

    logic pc1 = 0, pl1 = 0, pr1 = 0;
    logic chain1 = 0;
    int   rise1 = 0, lat1_len = 0, lat1_last = 0;
    int   acc1_q[$];
    int   rdy1_q[$];
    logic latq1[$];

    always @(negedge clk) begin
        if (valid1 && ready1) acc1_q.push_back(cyc + 1);
        if (ready1 && !pr1)   rdy1_q.push_back(cyc + 1);
        if (sc1 && !pc1) begin
            chain1 = sd1;
            rise1  = rise1 + 1;
        end
        if (sl1 && !pl1) begin
            latq1.push_back(chain1);
            lat1_len = 1;
        end else if (sl1) begin
            lat1_len = lat1_len + 1;
        end else if (pl1) begin
            lat1_last = lat1_len;
        end
        pc1 = sc1; pl1 = sl1; pr1 = ready1;
    end

    // ---------------- scenarios ----------------------------------------------
    task automatic test_reset();
        rst = 1'b1; valid0 = 1'b1; valid1 = 1'b1; data0 = 16'hFFFF; data1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({ready0, sd0, sc0, sl0, ready1, sd1, sc1, sl1} !== 8'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b want 00000000", i,
                         {ready0, sd0, sc0, sl0, ready1, sd1, sc1, sl1});
            end
        end
        checks++;
        if (acc0_q.size() + acc1_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_accept: got %0d accepts want 0", acc0_q.size() + acc1_q.size());
        end
        rst = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ready0, ready1} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 11", {ready0, ready1});
        end
    endtask

    task automatic test_single_frame();
        int na, nl, nr;
        logic [15:0] got;
        na = acc0_q.size(); nl = latq0.size(); nr = rdy0_q.size();
        rise0 = 0; stab0 = 0; hp0_err = 0;
        data0 = 16'hA5C3; valid0 = 1'b1;
        for (int i = 0; i < 20 && acc0_q.size() == na; i++) begin @(posedge clk); #1; end
        valid0 = 1'b0;
        data0  = 16'hFFFF;  // must not disturb the frame already in flight
        for (int i = 0; i < 200 && rdy0_q.size() == nr; i++) begin @(posedge clk); #1; end
        checks++;
        if (acc0_q.size() != na + 1 || rdy0_q.size() != nr + 1) begin
            errors++;
            $display("FAIL single_handshake: accepts %0d readies %0d want 1 and 1",
                     acc0_q.size() - na, rdy0_q.size() - nr);
        end
        got = (latq0.size() > nl) ? latq0[nl] : 16'hxxxx;
        $display("frame a5c3 latched %h", got);
        checks++;
        if (got !== 16'hA5C3) begin
            errors++;
            $display("FAIL single_latched: got %h want a5c3", got);
        end
        checks++;
        if (rise0 != 16) begin
            errors++;
            $display("FAIL single_clk_rises: got %0d want 16", rise0);
        end
        checks++;
        if (hp0_err != 0) begin
            errors++;
            $display("FAIL single_high_phase: got %0d bad phases want 0", hp0_err);
        end
        checks++;
        if (stab0 != 0) begin
            errors++;
            $display("FAIL data_stable_high: got %0d changes want 0", stab0);
        end
        checks++;
        if (lat0_last != 2) begin
            errors++;
            $display("FAIL single_latch_len: got %0d want 2", lat0_last);
        end
        checks++;
        if (acc0_q.size() > na && rdy0_q.size() > nr && rdy0_q[nr] - acc0_q[na] != 67) begin
            errors++;
            $display("FAIL single_ready_return: got %0d want 67", rdy0_q[nr] - acc0_q[na]);
        end
    endtask

    task automatic test_back_to_back();
        int na, nl;
        logic [15:0] g0, g1;
        na = acc0_q.size(); nl = latq0.size();
        data0 = 16'h0001; valid0 = 1'b1;
        for (int i = 0; i < 20 && acc0_q.size() == na; i++) begin @(posedge clk); #1; end
        data0 = 16'h8000;
        for (int i = 0; i < 200 && acc0_q.size() == na + 1; i++) begin @(posedge clk); #1; end
        valid0 = 1'b0;
        for (int i = 0; i < 200 && latq0.size() < nl + 2; i++) begin @(posedge clk); #1; end
        g0 = (latq0.size() > nl)     ? latq0[nl]     : 16'hxxxx;
        g1 = (latq0.size() > nl + 1) ? latq0[nl + 1] : 16'hxxxx;
        $display("frame 0001 latched %h", g0);
        $display("frame 8000 latched %h", g1);
        checks++;
        if (g0 !== 16'h0001 || g1 !== 16'h8000) begin
            errors++;
            $display("FAIL b2b_latched: got %h %h want 0001 8000", g0, g1);
        end
        checks++;
        if (acc0_q.size() < na + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d accepts want 2", acc0_q.size() - na);
        end else if (acc0_q[na + 1] - acc0_q[na] != 67) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d want 67", acc0_q[na + 1] - acc0_q[na]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int na, nl;
        logic [15:0] got;
        na = acc0_q.size(); nl = latq0.size();
        rise0 = 0;
        data0 = 16'($urandom); valid0 = 1'b1;
        for (int i = 0; i < 20 && acc0_q.size() == na; i++) begin @(posedge clk); #1; end
        valid0 = 1'b0;
        for (int i = 0; i < 200 && rise0 < 7; i++) begin @(posedge clk); #1; end
        checks++;
        if (rise0 != 7) begin
            errors++;
            $display("FAIL abort_reach_bit7: got %0d rises want 7", rise0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ready0, sd0, sc0, sl0} !== 4'b0) begin
            errors++;
            $display("FAIL abort_outputs: got %b want 0000", {ready0, sd0, sc0, sl0});
        end
        rst = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        checks++;
        if (latq0.size() != nl) begin
            errors++;
            $display("FAIL abort_no_latch: got %0d latches want 0", latq0.size() - nl);
        end
        na = acc0_q.size();
        data0 = 16'h1234; valid0 = 1'b1;
        for (int i = 0; i < 20 && acc0_q.size() == na; i++) begin @(posedge clk); #1; end
        valid0 = 1'b0;
        for (int i = 0; i < 200 && latq0.size() == nl; i++) begin @(posedge clk); #1; end
        got = (latq0.size() > nl) ? latq0[nl] : 16'hxxxx;
        $display("frame 1234 latched %h", got);
        checks++;
        if (got !== 16'h1234) begin
            errors++;
            $display("FAIL abort_next_frame: got %h want 1234", got);
        end
    endtask

    task automatic test_random_frames();
        logic [15:0] exp_v, got;
        int na, nl, nr;
        for (int f = 0; f < 5; f++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            exp_v = 16'($urandom);
            na = acc0_q.size(); nl = latq0.size(); nr = rdy0_q.size();
            data0 = exp_v; valid0 = 1'b1;
            for (int i = 0; i < 20 && acc0_q.size() == na; i++) begin @(posedge clk); #1; end
            valid0 = 1'b0;
            data0 = 16'($urandom);
            for (int i = 0; i < 200 && rdy0_q.size() == nr; i++) begin @(posedge clk); #1; end
            got = (latq0.size() > nl) ? latq0[nl] : 16'hxxxx;
            $display("frame %h latched %h", exp_v, got);
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL random_frame %0d: got %h want %h", f, got, exp_v);
            end
        end
    endtask

    task automatic test_edge_params();
        int na, nl, nr;
        logic got;
        na = acc1_q.size(); nl = latq1.size(); nr = rdy1_q.size();
        rise1 = 0;
        data1 = 1'b1; valid1 = 1'b1;
        for (int i = 0; i < 20 && acc1_q.size() == na; i++) begin @(posedge clk); #1; end
        valid1 = 1'b0; data1 = 1'b0;
        for (int i = 0; i < 50 && rdy1_q.size() == nr; i++) begin @(posedge clk); #1; end
        got = (latq1.size() > nl) ? latq1[nl] : 1'bx;
        $display("frame 1 (width 1) latched %b", got);
        checks++;
        if (got !== 1'b1 || rise1 != 1) begin
            errors++;
            $display("FAIL edge_frame: got bit %b rises %0d want bit 1 rises 1", got, rise1);
        end
        checks++;
        if (lat1_last != 1) begin
            errors++;
            $display("FAIL edge_latch_len: got %0d want 1", lat1_last);
        end
        checks++;
        if (acc1_q.size() <= na || rdy1_q.size() <= nr) begin
            errors++;
            $display("FAIL edge_ready_return: got no handshake/ready want 4");
        end else if (rdy1_q[nr] - acc1_q[na] != 4) begin
            errors++;
            $display("FAIL edge_ready_return: got %0d want 4", rdy1_q[nr] - acc1_q[na]);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
        test_edge_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
